// File: rtl/seg_scan_ctrl.sv
// Seven-segment scan controller: 8-bit binary -> 3 BCD digits (sequential double-dabble), multiplexed onto a common-anode bank.
// Optional leading-zero blanking when SEG_LZB_EN is defined.
module seg_scan_ctrl #(
    parameter int REFRESH_DIV = 50000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] value,
    input  logic       value_valid,
    output logic       busy,
    output logic       conv_done,
    output logic [6:0] seg_n,
    output logic [7:0] an_n,
    output logic       dp_n
);

    // state | meaning
    // IDLE  | waiting for value_valid, display registers stable
    // CONV  | one add-3/shift step per cycle, commit on the 8th shift
    typedef enum logic {
        IDLE = 1'b0,
        CONV = 1'b1
    } state_t;

    localparam int PW = (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 1;
    localparam logic [PW-1:0] PRE_LAST = PW'(REFRESH_DIV - 1);

    state_t      state;
    state_t      state_next;

    logic [7:0]  shreg;
    logic [11:0] scratch;
    logic [3:0]  bit_cnt;
    logic [11:0] scratch_adj;
    logic [19:0] shifted;

    logic        load;
    logic        shift_en;
    logic        commit;

    logic [3:0]  hund;
    logic [3:0]  tens;
    logic [3:0]  ones;

    logic [PW-1:0] pre;
    logic          tick;
    logic [1:0]    slot;
    logic [1:0]    slot_next;
    logic [6:0]    seg_next;
    logic [7:0]    an_next;

    function automatic logic [3:0] add3(input logic [3:0] n);
        return (n >= 4'd5) ? (n + 4'd3) : n;
    endfunction

    function automatic logic [6:0] seg_decode(input logic [3:0] d);
        logic [6:0] p;
        case (d)
            4'd0:    p = 7'b1000000;
            4'd1:    p = 7'b1111001;
            4'd2:    p = 7'b0100100;
            4'd3:    p = 7'b0110000;
            4'd4:    p = 7'b0011001;
            4'd5:    p = 7'b0010010;
            4'd6:    p = 7'b0000010;
            4'd7:    p = 7'b1111000;
            4'd8:    p = 7'b0000000;
            4'd9:    p = 7'b0010000;
            default: p = 7'b1111111;
        endcase
        return p;
    endfunction

    // ---------------- conversion FSM ----------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (value_valid) state_next = CONV;
            CONV:    if (bit_cnt == 4'd7) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        busy     = 1'b0;
        load     = 1'b0;
        shift_en = 1'b0;
        commit   = 1'b0;
        case (state)
            IDLE: load = value_valid;
            CONV: begin
                busy     = 1'b1;
                shift_en = 1'b1;
                commit   = (bit_cnt == 4'd7);
            end
            default: ;
        endcase
    end

    // ---------------- double-dabble datapath ----------------
    always_comb begin
        scratch_adj = {add3(scratch[11:8]), add3(scratch[7:4]), add3(scratch[3:0])};
        shifted     = {scratch_adj, shreg} << 1;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            shreg     <= '0;
            scratch   <= '0;
            bit_cnt   <= '0;
            hund      <= '0;
            tens      <= '0;
            ones      <= '0;
            conv_done <= 1'b0;
        end else begin
            conv_done <= commit;
            if (load) begin
                shreg   <= value;
                scratch <= '0;
                bit_cnt <= '0;
            end else if (shift_en) begin
                {scratch, shreg} <= shifted;
                bit_cnt          <= bit_cnt + 4'd1;
            end
            if (commit) begin
                hund <= shifted[19:16];
                tens <= shifted[15:12];
                ones <= shifted[11:8];
            end
        end
    end

    // ---------------- scan ----------------
    assign tick      = (pre == PRE_LAST);
    assign slot_next = slot + 2'd1;

    // Pattern for the slot about to be selected; uses the digits held before any same-edge commit.
    always_comb begin
        seg_next = 7'h7F;
        an_next  = 8'hFF;
        case (slot_next)
            2'd0: begin
                an_next  = 8'hFE;
                seg_next = seg_decode(ones);
            end
            2'd1: begin
                an_next  = 8'hFD;
                seg_next = seg_decode(tens);
`ifdef SEG_LZB_EN
                if ((hund == 4'd0) && (tens == 4'd0)) an_next = 8'hFF;
`endif
            end
            2'd2: begin
                an_next  = 8'hFB;
                seg_next = seg_decode(hund);
`ifdef SEG_LZB_EN
                if (hund == 4'd0) an_next = 8'hFF;
`endif
            end
            default: begin
                an_next  = 8'hFF;
                seg_next = 7'h7F;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pre   <= '0;
            slot  <= 2'd3;
            seg_n <= 7'h7F;
            an_n  <= 8'hFF;
        end else begin
            if (tick) begin
                pre   <= '0;
                slot  <= slot_next;
                seg_n <= seg_next;
                an_n  <= an_next;
            end else begin
                pre <= pre + 1'b1;
            end
        end
    end

    assign dp_n = 1'b1;

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Scoreboard bench for seg_scan_ctrl with REFRESH_DIV=4: behavioural reference model plus decoupled monitor.
module tb_seg_scan_ctrl;

    localparam int DIV = 4;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [7:0] value = 8'd0;
    logic       value_valid = 1'b0;
    logic       busy;
    logic       conv_done;
    logic [6:0] seg_n;
    logic [7:0] an_n;
    logic       dp_n;

    seg_scan_ctrl #(.REFRESH_DIV(DIV)) dut (
        .clk         (clk),
        .reset       (reset),
        .value       (value),
        .value_valid (value_valid),
        .busy        (busy),
        .conv_done   (conv_done),
        .seg_n       (seg_n),
        .an_n        (an_n),
        .dp_n        (dp_n)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    logic [6:0] seg_tab [10] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78, 7'h00, 7'h10};

    // Reference model state: plain counts and decimal digits
    int         m_cnt = 0;
    int         m_pre = 0;
    int         m_slot = 3;
    int         m_h = 0, m_t = 0, m_o = 0;
    int         p_val = 0;
    logic [6:0] e_seg = 7'h7F;
    logic [7:0] e_an  = 8'hFF;
    logic       e_done = 1'b0;
    int         exp_q [$];

    always @(posedge clk) begin
        bit tk;
        if (reset) begin
            m_cnt = 0; m_pre = 0; m_slot = 3;
            m_h = 0; m_t = 0; m_o = 0;
            e_seg = 7'h7F; e_an = 8'hFF; e_done = 1'b0;
            exp_q.delete();
        end else begin
            tk    = (m_pre == DIV - 1);
            m_pre = (m_pre + 1) % DIV;
            if (tk) begin
                m_slot = (m_slot + 1) % 4;
                case (m_slot)
                    0: begin e_an = 8'hFE; e_seg = seg_tab[m_o]; end
                    1: begin
                        e_an = 8'hFD; e_seg = seg_tab[m_t];
`ifdef SEG_LZB_EN
                        if (m_h == 0 && m_t == 0) e_an = 8'hFF;
`endif
                    end
                    2: begin
                        e_an = 8'hFB; e_seg = seg_tab[m_h];
`ifdef SEG_LZB_EN
                        if (m_h == 0) e_an = 8'hFF;
`endif
                    end
                    default: begin e_an = 8'hFF; e_seg = 7'h7F; end
                endcase
            end
            e_done = 1'b0;
            if (m_cnt > 0) begin
                m_cnt--;
                if (m_cnt == 0) begin
                    m_h = p_val / 100;
                    m_t = (p_val / 10) % 10;
                    m_o = p_val % 10;
                    e_done = 1'b1;
                end
            end else if (value_valid) begin
                m_cnt = 8;
                p_val = value;
                exp_q.push_back(int'(value));
            end
        end
    end

    // Monitor: compares every cycle, pops the scoreboard on each conv_done
    always @(negedge clk) begin
        int v;
        if (reset) begin
            check("rst_busy", busy, 0);
            check("rst_done", conv_done, 0);
            check("rst_seg", seg_n, 7'h7F);
            check("rst_an", an_n, 8'hFF);
            check("rst_dp", dp_n, 1);
        end else begin
            check("busy", busy, (m_cnt > 0));
            check("conv_done", conv_done, e_done);
            check("seg_n", seg_n, e_seg);
            check("an_n", an_n, e_an);
            check("dp_n", dp_n, 1);
            if (conv_done) begin
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL spurious_conv_done: got pulse expected none at %0t", $time);
                end else begin
                    v = exp_q.pop_front();
                    check("digits", dut.hund * 100 + dut.tens * 10 + dut.ones, v);
                end
            end
        end
    end

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #2;
        end
    endtask

    task automatic strobe(input logic [7:0] v, input int len);
        value = v;
        value_valid = 1'b1;
        idle(len);
        value_valid = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        @(posedge clk); #2;
        idle(2);
        reset = 1'b0;
        idle(16);

        strobe(8'd255, 1); idle(14);
        strobe(8'd123, 1); idle(1); strobe(8'd45, 1); idle(14);

        strobe(8'd200, 1); idle(3);
        reset = 1'b1;
        #1;
        check("abort_busy", busy, 0);
        check("abort_done", conv_done, 0);
        check("abort_digits", {dut.hund, dut.tens, dut.ones}, 12'h000);
        idle(2);
        reset = 1'b0;
        idle(4);

        strobe(8'd7, 1); idle(20);
        strobe(8'd100, 1); idle(8); strobe(8'd99, 1); idle(20);

        for (int i = 0; i < 30; i++) begin
            strobe(8'($urandom_range(0, 255)), $urandom_range(1, 3));
            idle($urandom_range(0, 12));
        end
        idle(20);
        check("queue_drained", exp_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
